vga_layer_compositor: RTL and testbench
=======================================

// Module: vga_layer_compositor
// PURPOSE
//  Parametrised VGA core: timing generator plus N-layer priority compositor. Replaces the fixed
//  2-layer (character/pong) mux. Exports raw beam coordinates to layer sources, re-aligns their
//  pipelined pixels with sync, and emits registered RGB/hsync/vsync/de. Layer enables and the
//  background colour are double-buffered and take effect only at the start of vertical blanking.
// PARAMETERS
//  H_ACTIVE 640 / H_FP 16 / H_SYNC 96 / H_BP 48 : horizontal timing, pixels
//  V_ACTIVE 480 / V_FP 10 / V_SYNC 2 / V_BP 33  : vertical timing, lines
//  HS_POL 0, VS_POL 0 : sync asserted level (0 = active-low)
//  NUM_LAYERS 4       : layer count; index 0 = highest priority
//  COLOR_BITS 2       : bits per colour channel
//  LAYER_LAT 2        : cycles from x/y out to layer_* in (>=0)
// PORTS
//  clk         in  1               system clock
//  rst         in  1               async reset, active-high
//  pix_en      in  1               pixel-clock enable; all state advances only when high
//  cfg_valid   in  1               write pending config this cycle
//  cfg_layer_en in NUM_LAYERS      pending per-layer enable
//  cfg_bg_rgb  in  3*COLOR_BITS    pending background colour {R,G,B}
//  x           out 10              horizontal counter, 0..H_TOTAL-1
//  y           out 10              vertical counter, 0..V_TOTAL-1
//  frame_start out 1               1-cycle pulse (qualified by pix_en) when x==0,y==0
//  layer_valid in  NUM_LAYERS      per-layer opaque flag, LAYER_LAT after x/y
//  layer_rgb   in  NUM_LAYERS*3*COLOR_BITS  per-layer colour, layer i at [i*3*CB +: 3*CB]
//  hsync, vsync out 1              registered syncs
//  de          out 1               registered data-enable (active area)
//  rgb         out 3*COLOR_BITS    registered pixel colour
// BEHAVIOUR
//  - Reset: x=y=0; hsync=~HS_POL, vsync=~VS_POL (deasserted); de=0; rgb=0; frame_start=0;
//    pending and active cfg: layer_en=all 1s, bg=0; alignment pipeline cleared to blank.
//  - pix_en=0: every register holds, including pending cfg writes (cfg_valid ignored).
//  - Counters: x increments per pix_en; at H_TOTAL-1 wraps to 0 and y increments; y wraps to 0
//    after V_TOTAL-1. H_TOTAL/V_TOTAL = sum of four timing params each.
//  - Raw per-pixel: active=(x<H_ACTIVE)&&(y<V_ACTIVE); hs on for H_ACTIVE+H_FP<=x<H_ACTIVE+H_FP+H_SYNC;
//    vs likewise on y.
//  - Alignment: active/hs/vs delayed LAYER_LAT stages (shift regs), joined with layer inputs,
//    then one output register. Beam at cycle t -> outputs at t+LAYER_LAT+1 (enabled cycles).
//  - Compose: lowest i with layer_valid[i] && active_layer_en[i] wins; none -> active bg.
//    de=0 -> rgb forced 0 regardless of layers.
//  - Config: cfg_valid latches into pending regs (last write wins). Apply cycle = x==0 &&
//    y==V_ACTIVE: active<=pending; if cfg_valid in the apply cycle, the new value is applied
//    directly (bypass). Active cfg never changes mid-frame.
//  - Reset mid-frame: immediate return to reset state; no partial line emitted; next
//    frame_start one enabled cycle after rst deasserts.
// STRUCTURE
//  - vga_pkg: timing defaults, H_TOTAL/V_TOTAL functions, rgb width localparam.
//  - Sub-module vga_timing_gen (counters, raw active/hs/vs, frame_start); compositor,
//    alignment pipe, and cfg double-buffer stay in this module.
// TESTING
//  - Reset, pix_en=1, run 420000 cycles -> frame_start period exactly 800*525; hsync low 96
//    cycles per line, vsync low 2 lines; first de high at cycle LAYER_LAT+1.
//  - layer_valid=4'b0110, layer0 red, layer1 green, layer2 blue -> rgb=green (6'b001100) in
//    active area; rgb=0 while de=0.
//  - cfg_valid mid-frame with layer_en=4'b1101, bg=6'b111111 -> output unchanged until
//    y==480,x==0; next frame layer1 masked, empty pixels = white.
//  - cfg_valid asserted exactly at apply cycle -> new cfg active that frame; two writes in
//    one frame -> only the last applied.
//  - pix_en toggled 1/0 -> timing identical to continuous run at half rate; cfg_valid while
//    pix_en=0 discarded.
//  - rst pulse at x=300,y=200 -> all outputs at reset values next edge; x/y restart at 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing defaults and helpers for the VGA core.
// Provides default 640x480@60 timing, frame totals and the RGB bus width.
package vga_pkg;

  localparam int H_ACTIVE_D   = 640;
  localparam int H_FP_D       = 16;
  localparam int H_SYNC_D     = 96;
  localparam int H_BP_D       = 48;
  localparam int V_ACTIVE_D   = 480;
  localparam int V_FP_D       = 10;
  localparam int V_SYNC_D     = 2;
  localparam int V_BP_D       = 33;
  localparam int COLOR_BITS_D = 2;

  function automatic int h_total(
    int a, int fp, int s, int bp
  );
    return a + fp + s + bp;
  endfunction

  function automatic int v_total(
    int a, int fp, int s, int bp
  );
    return a + fp + s + bp;
  endfunction

  function automatic int rgb_w(int cb);
    return 3 * cb;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Beam counters, raw active/hsync/vsync flags and frame-start pulse.
// Ports: i_clk, i_rst, i_pix_en in; o_x, o_y, o_frame_start, o_active, o_hs, o_vs out.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_en,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_frame_start,
  output logic       o_active,
  output logic       o_hs,
  output logic       o_vs
);

  localparam logic [9:0] HL =
    10'(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [9:0] VL =
    10'(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [9:0] HA  = 10'(H_ACTIVE);
  localparam logic [9:0] VA  = 10'(V_ACTIVE);
  localparam logic [9:0] HSS = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSE = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VSS = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSE = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_fs;

  // The pulse clears on every clock so it stays one cycle wide
  // even when pix_en stalls the counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x  <= '0;
      r_y  <= '0;
      r_fs <= 1'b0;
    end else begin
      r_fs <= i_pix_en && (r_x == '0) && (r_y == '0);
      if (i_pix_en) begin
        if (r_x == HL) begin
          r_x <= '0;
          r_y <= (r_y == VL) ? '0 : r_y + 10'd1;
        end else begin
          r_x <= r_x + 10'd1;
        end
      end
    end
  end

  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_frame_start = r_fs;
  assign o_active      = (r_x < HA) && (r_y < VA);
  assign o_hs          = (r_x >= HSS) && (r_x < HSE);
  assign o_vs          = (r_y >= VSS) && (r_y < VSE);

endmodule

// File: rtl/vga_layer_compositor.sv
// VGA timing plus N-layer priority compositor with double-buffered config.
// Ports: clk, rst, pix_en, cfg_* in; x, y, frame_start out; layer_* in; hsync, vsync, de, rgb out.
module vga_layer_compositor
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_D,
  parameter int H_FP       = H_FP_D,
  parameter int H_SYNC     = H_SYNC_D,
  parameter int H_BP       = H_BP_D,
  parameter int V_ACTIVE   = V_ACTIVE_D,
  parameter int V_FP       = V_FP_D,
  parameter int V_SYNC     = V_SYNC_D,
  parameter int V_BP       = V_BP_D,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_BITS = COLOR_BITS_D,
  parameter int LAYER_LAT  = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               pix_en,
  input  logic                               cfg_valid,
  input  logic [NUM_LAYERS-1:0]              cfg_layer_en,
  input  logic [rgb_w(COLOR_BITS)-1:0]       cfg_bg_rgb,
  output logic [9:0]                         x,
  output logic [9:0]                         y,
  output logic                               frame_start,
  input  logic [NUM_LAYERS-1:0]              layer_valid,
  input  logic [NUM_LAYERS*rgb_w(COLOR_BITS)-1:0] layer_rgb,
  output logic                               hsync,
  output logic                               vsync,
  output logic                               de,
  output logic [rgb_w(COLOR_BITS)-1:0]       rgb
);

  localparam int RGB_W = rgb_w(COLOR_BITS);
  localparam logic [9:0] VA = 10'(V_ACTIVE);

  logic       w_active;
  logic       w_hs;
  logic       w_vs;
  logic [2:0] w_raw;
  logic [2:0] w_al;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_pix_en      (pix_en),
    .o_x           (x),
    .o_y           (y),
    .o_frame_start (frame_start),
    .o_active      (w_active),
    .o_hs          (w_hs),
    .o_vs          (w_vs)
  );

  assign w_raw = {w_active, w_hs, w_vs};

  // Delay beam flags so they meet the layer pixels for the same beam.
  generate
    if (LAYER_LAT > 0) begin : g_pipe
      logic [2:0] r_pipe [LAYER_LAT];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < LAYER_LAT; i++)
            r_pipe[i] <= '0;
        end else if (pix_en) begin
          r_pipe[0] <= w_raw;
          for (int i = 1; i < LAYER_LAT; i++)
            r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_al = r_pipe[LAYER_LAT-1];
    end else begin : g_nopipe
      assign w_al = w_raw;
    end
  endgenerate

  logic [NUM_LAYERS-1:0] r_pend_en;
  logic [RGB_W-1:0]      r_pend_bg;
  logic [NUM_LAYERS-1:0] r_act_en;
  logic [RGB_W-1:0]      r_act_bg;
  logic                  w_apply;

  // Start of vertical blanking: the only point the active set moves.
  assign w_apply = (x == '0) && (y == VA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_en <= '1;
      r_pend_bg <= '0;
      r_act_en  <= '1;
      r_act_bg  <= '0;
    end else if (pix_en) begin
      if (cfg_valid) begin
        r_pend_en <= cfg_layer_en;
        r_pend_bg <= cfg_bg_rgb;
      end
      if (w_apply) begin
        r_act_en <= cfg_valid ? cfg_layer_en : r_pend_en;
        r_act_bg <= cfg_valid ? cfg_bg_rgb : r_pend_bg;
      end
    end
  end

  logic [RGB_W-1:0] w_pix;

  // Walk from lowest priority up so index 0 lands last and wins.
  always_comb begin
    w_pix = r_act_bg;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_valid[i] && r_act_en[i])
        w_pix = layer_rgb[i*RGB_W +: RGB_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de    <= 1'b0;
      rgb   <= '0;
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
    end else if (pix_en) begin
      de    <= w_al[2];
      rgb   <= w_al[2] ? w_pix : '0;
      hsync <= w_al[1] ? HS_POL : ~HS_POL;
      vsync <= w_al[0] ? VS_POL : ~VS_POL;
    end
  end

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Directed bench for vga_layer_compositor on a reduced 25x13 raster.
// Table-driven compositor vectors plus sequences for config, pix_en and reset.
module tb_vga_layer_compositor;

  localparam int LAT = 2;
  localparam int HT  = 25;
  localparam int VT  = 13;

  logic       clk;
  logic       rst;
  logic       pix_en;
  logic       cfg_valid;
  logic [3:0] cfg_layer_en;
  logic [5:0] cfg_bg_rgb;
  logic [9:0] x;
  logic [9:0] y;
  logic       frame_start;
  logic [3:0] layer_valid;
  logic [23:0] layer_rgb;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [5:0] rgb;

  vga_layer_compositor #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
    .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (2),
    .HS_POL (1'b0), .VS_POL (1'b0),
    .NUM_LAYERS (4), .COLOR_BITS (2), .LAYER_LAT (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pix_en       (pix_en),
    .cfg_valid    (cfg_valid),
    .cfg_layer_en (cfg_layer_en),
    .cfg_bg_rgb   (cfg_bg_rgb),
    .x            (x),
    .y            (y),
    .frame_start  (frame_start),
    .layer_valid  (layer_valid),
    .layer_rgb    (layer_rgb),
    .hsync        (hsync),
    .vsync        (vsync),
    .de           (de),
    .rgb          (rgb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  bit tog   = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (tog) pix_en = ~pix_en;
    end
  end

  typedef struct {
    logic [3:0] lv;
    logic [9:0] bx;
    logic [9:0] by;
    logic [5:0] rgb;
    logic       de;
    logic       hs;
    logic       vs;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic wait_beam(input logic [9:0] bx, input logic [9:0] by);
    int n;
    n = 0;
    @(negedge clk);
    while (!(x == bx && y == by) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_beam timeout at (%0d,%0d)", bx, by);
    end
  endtask

  task automatic probe(input string nm, input logic [9:0] bx,
                       input logic [9:0] by, input logic [5:0] exp);
    wait_beam(bx, by);
    repeat (LAT + 1) @(posedge clk);
    @(negedge clk);
    chk(nm, int'(rgb), int'(exp));
  endtask

  task automatic cfg_write(input logic [3:0] en, input logic [5:0] bg);
    cfg_valid    = 1'b1;
    cfg_layer_en = en;
    cfg_bg_rgb   = bg;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic measure(output int per, output int hl,
                         output int vl, output int dh);
    int n;
    per = 0; hl = 0; vl = 0; dh = 0;
    n = 0;
    @(negedge clk);
    while (!frame_start && n < 4000) begin
      @(negedge clk);
      n++;
    end
    while (n < 4000) begin
      @(negedge clk);
      n++;
      per++;
      if (!hsync) hl++;
      if (!vsync) vl++;
      if (de) dh++;
      if (frame_start) break;
    end
    if (n >= 4000) begin
      n_vec++;
      n_err++;
      $display("FAIL measure timeout");
    end
  endtask

  initial begin
    int per, hl, vl, dh, first_de;
    logic [9:0] xs;

    tbl[0] = '{4'b0110, 10'd8,  10'd3,  6'b001100, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{4'b0001, 10'd0,  10'd0,  6'b110000, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{4'b0000, 10'd15, 10'd7,  6'b000000, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{4'b1000, 10'd5,  10'd2,  6'b010101, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{4'b1100, 10'd9,  10'd6,  6'b000011, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{4'b1111, 10'd3,  10'd4,  6'b110000, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{4'b1111, 10'd18, 10'd3,  6'b000000, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{4'b1111, 10'd2,  10'd9,  6'b000000, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{4'b1111, 10'd21, 10'd10, 6'b000000, 1'b0, 1'b0, 1'b0};

    rst          = 1'b1;
    pix_en       = 1'b1;
    cfg_valid    = 1'b0;
    cfg_layer_en = 4'b0000;
    cfg_bg_rgb   = 6'b000000;
    layer_valid  = 4'b0000;
    layer_rgb    = {6'b010101, 6'b000011, 6'b001100, 6'b110000};

    repeat (3) @(negedge clk);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_hs", int'(hsync), 1);
    chk("rst_vs", int'(vsync), 1);
    chk("rst_de", int'(de), 0);
    chk("rst_rgb", int'(rgb), 0);
    chk("rst_fs", int'(frame_start), 0);

    rst = 1'b0;
    first_de = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) chk("fs_first", int'(frame_start), 1);
      if (de && first_de < 0) first_de = k;
    end
    chk("first_de_cycle", first_de, LAT + 1);

    measure(per, hl, vl, dh);
    chk("frame_period", per, HT * VT);
    chk("hsync_low", hl, 4 * VT);
    chk("vsync_low", vl, 2 * HT);
    chk("de_high", dh, 16 * 8);

    foreach (tbl[i]) begin
      layer_valid = tbl[i].lv;
      wait_beam(tbl[i].bx, tbl[i].by);
      repeat (LAT + 1) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_rgb", i), int'(rgb), int'(tbl[i].rgb));
      chk($sformatf("vec%0d_de", i), int'(de), int'(tbl[i].de));
      chk($sformatf("vec%0d_hs", i), int'(hsync), int'(tbl[i].hs));
      chk($sformatf("vec%0d_vs", i), int'(vsync), int'(tbl[i].vs));
    end

    // mid-frame write held until vertical blanking
    layer_valid = 4'b0110;
    wait_beam(10'd0, 10'd2);
    cfg_write(4'b1101, 6'b111111);
    probe("cfg_hold_layer", 10'd8, 10'd4, 6'b001100);
    layer_valid = 4'b0000;
    probe("cfg_hold_bg", 10'd8, 10'd5, 6'b000000);
    layer_valid = 4'b0110;
    probe("cfg_mask_l1", 10'd8, 10'd1, 6'b000011);
    layer_valid = 4'b0000;
    probe("cfg_bg_white", 10'd8, 10'd2, 6'b111111);

    // write exactly in the apply cycle bypasses pending
    wait_beam(10'd0, 10'd8);
    cfg_write(4'b1111, 6'b010000);
    layer_valid = 4'b0110;
    probe("bypass_layer", 10'd8, 10'd1, 6'b001100);
    layer_valid = 4'b0000;
    probe("bypass_bg", 10'd8, 10'd2, 6'b010000);

    // two writes in one frame: last wins
    wait_beam(10'd0, 10'd2);
    cfg_write(4'b0111, 6'b000001);
    wait_beam(10'd0, 10'd4);
    cfg_write(4'b1110, 6'b001111);
    layer_valid = 4'b0001;
    probe("last_wr_bg", 10'd8, 10'd1, 6'b001111);
    layer_valid = 4'b1000;
    probe("last_wr_l3", 10'd8, 10'd2, 6'b010101);

    // write while stalled is dropped, counters hold
    wait_beam(10'd3, 10'd3);
    xs = x;
    pix_en = 1'b0;
    cfg_write(4'b0000, 6'b110011);
    chk("stall_x_hold", int'(x), int'(xs));
    pix_en = 1'b1;
    layer_valid = 4'b0000;
    wait_beam(10'd1, 10'd8);
    probe("stall_drop_bg", 10'd8, 10'd1, 6'b001111);
    layer_valid = 4'b1000;
    probe("stall_drop_l3", 10'd8, 10'd2, 6'b010101);

    // half-rate enable
    tog = 1'b1;
    measure(per, hl, vl, dh);
    measure(per, hl, vl, dh);
    tog = 1'b0;
    @(negedge clk);
    pix_en = 1'b1;
    chk("half_period", per, 2 * HT * VT);
    chk("half_hsync_low", hl, 2 * 4 * VT);
    chk("half_vsync_low", vl, 2 * 2 * HT);
    chk("half_de_high", dh, 2 * 16 * 8);

    // async reset mid-frame
    layer_valid = 4'b1111;
    wait_beam(10'd10, 10'd5);
    rst = 1'b1;
    #1;
    chk("mrst_x", int'(x), 0);
    chk("mrst_y", int'(y), 0);
    chk("mrst_de", int'(de), 0);
    chk("mrst_rgb", int'(rgb), 0);
    chk("mrst_hs", int'(hsync), 1);
    chk("mrst_vs", int'(vsync), 1);
    chk("mrst_fs", int'(frame_start), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_fs_next", int'(frame_start), 1);
    chk("mrst_x_next", int'(x), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
